bcd_digit_collector: RTL and testbench
======================================

// Module: bcd_digit_collector
// PURPOSE
//   Sequencer and collector wrapped around bcd_sequential (26-bit bin -> 8 BCD digits).
//   Accepts a binary value over a valid/ready handshake and holds it on conv_bin.
//   Pulses conv_bin_en once, then conv_next_quotient once per later digit, and samples conv_dec, MSD first.
//   Presents the packed 8-digit BCD word plus a leading-zero blank mask to the display/UART stage downstream.
// PARAMETERS
//   FIRST_WAIT  4  cycles from the conv_bin_en cycle to the digit-7 sample cycle (converter uses 3 op cycles)
//   NEXT_WAIT   5  cycles from one sample cycle to the next (converter uses 4 op cycles per digit)
//   DIGITS      8  digits collected; fixed by the converter, not to be overridden
// PORTS
//   SYS_clk             in   1   system clock, all logic on rising edge
//   reset               in   1   synchronous, active-high reset
//   in_valid            in   1   in_bin is valid
//   in_ready            out  1   high only in IDLE with out_valid low
//   in_bin              in   26  binary value, 0..67_108_863
//   conv_bin            out  26  held copy of the accepted value -> bcd_sequential.bin_in
//   conv_bin_en         out  1   one-cycle start pulse -> bcd_sequential.bin_en
//   conv_next_quotient  out  1   one-cycle next-digit pulse -> bcd_sequential.next_quotient
//   conv_dec            in   4   bcd_sequential.dec_out
//   busy                out  1   high from acceptance until out_valid rises
//   out_valid           out  1   bcd_out/blank_mask valid, held until taken
//   out_ready           in   1   downstream takes the result when out_valid & out_ready
//   bcd_out             out  32  digit7 in [31:28] ... digit0 in [3:0]
//   blank_mask          out  8   bit k=1: digit k is a leading zero; bit 0 always 0
// BEHAVIOUR
//   Reset: all outputs 0 except in_ready; in_ready=1 in the cycle after reset deasserts.
//          FSM -> IDLE; conv_bin, bcd_out, blank_mask, counters cleared.
//   Reset mid-operation aborts the conversion; no out_valid is produced for the aborted value.
//   FSM states: IDLE, START, WAIT, SAMPLE, DONE.
//   IDLE: on the edge with in_valid & in_ready:
//     - latch in_bin into conv_bin
//     - clear bcd_out; digit index = 7
//     - go to START
//   START: conv_bin_en=1 for exactly this cycle; wait counter = FIRST_WAIT-1; go to WAIT.
//   WAIT: decrement counter; at 0 go to SAMPLE.
//   SAMPLE: capture conv_dec into nibble[index] at the end of the cycle.
//     - index>0: conv_next_quotient=1 in this same cycle; the converter clears dec_out only after this edge.
//       Then index-1, counter = NEXT_WAIT-1, go to WAIT.
//     - index=0: no pulse; go to DONE.
//   DONE: out_valid=1, busy=0; bcd_out and blank_mask stable.
//     - out_valid & out_ready -> IDLE (in_ready rises the next cycle)
//   Timing: acceptance edge = cycle 0; conv_bin_en in cycle 1; digit 7 sampled in cycle 5; digit k sampled in cycle 5+5*(7-k).
//     - digit 0 sampled in cycle 40; out_valid from cycle 41
//   conv_bin is never changed while busy or out_valid; in_bin changes after acceptance are ignored.
//   in_valid while not ready: no effect, no queuing.
//   blank_mask computed combinationally from bcd_out, registered on entry to DONE:
//     - bit k (k>=1) = 1 when nibbles 7..k are all zero
//   Digit 7 never exceeds 6 (input max 67_108_863); a captured nibble >9 is stored unmodified.
//   conv_bin_en and conv_next_quotient are never high together, and neither is high outside START/SAMPLE.
// TESTING
//   1 in_bin=12_345_678 -> bcd_out=32'h1234_5678, blank_mask=8'h00, out_valid first high in cycle 41.
//   2 in_bin=0 -> bcd_out=0, blank_mask=8'hFE; in_bin=1000 -> 32'h0000_1000, mask 8'hF0.
//   3 in_bin=67_108_863 -> bcd_out=32'h6710_8863, mask 8'h00; conv_bin_en pulses once, conv_next_quotient exactly 7 times.
//   4 out_ready=0 for 20 cycles in DONE -> out_valid, bcd_out held, in_ready=0; second in_valid is ignored until the handshake completes.
//   5 in_bin toggled every cycle after acceptance of 40_000_000 -> conv_bin stays constant; bcd_out=32'h4000_0000.
//   6 reset pulsed in cycle 20 of a conversion -> outputs cleared next cycle; no out_valid; a new request then converts correctly.

Source files
------------

// File: rtl/bcd_digit_collector.sv
// Sequencer/collector around bcd_sequential. It starts a conversion, pulses next_quotient
// once per digit, captures the digits MSD first and presents a packed BCD word with a blank mask.
module bcd_digit_collector #(
  parameter int FIRST_WAIT = 4,
  parameter int NEXT_WAIT  = 5
) (
  input  logic        SYS_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_bin,
  output logic [25:0] conv_bin,
  output logic        conv_bin_en,
  output logic        conv_next_quotient,
  input  logic [3:0]  conv_dec,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] bcd_out,
  output logic [7:0]  blank_mask
);

  localparam int DIGITS = 8;
  localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);
  localparam logic [3:0] FW_LD    = 4'(FIRST_WAIT - 1);
  localparam logic [3:0] NW_LD    = 4'(NEXT_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  idx;
  logic [7:0]  blank_c;
  logic        zero_run;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      // Leave WAIT on the cycle the counter reaches zero, so SAMPLE lands exactly W cycles on
      S_WAIT:   if (cnt <= 4'd1) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (idx == 3'd0) ? S_DONE : S_WAIT;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign in_ready           = (state == S_IDLE);
  assign conv_bin_en        = (state == S_START);
  assign conv_next_quotient = (state == S_SAMPLE) && (idx != 3'd0);
  assign busy               = (state == S_START) || (state == S_WAIT) || (state == S_SAMPLE);
  assign out_valid          = (state == S_DONE);

  // Leading-zero run from the MSD down; digit 0 is always shown
  always_comb begin
    blank_c  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (bcd_out[k*4 +: 4] == 4'd0);
      blank_c[k] = zero_run;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      conv_bin   <= '0;
      bcd_out    <= '0;
      blank_mask <= '0;
      cnt        <= '0;
      idx        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (in_valid) begin
          conv_bin <= in_bin;
          bcd_out  <= '0;
          idx      <= IDX_LAST;
        end
        S_START: cnt <= FW_LD;
        S_WAIT:  cnt <= cnt - 4'd1;
        S_SAMPLE: begin
          bcd_out[{idx, 2'b00} +: 4] <= conv_dec;
          if (idx != 3'd0) begin
            idx <= idx - 3'd1;
            cnt <= NW_LD;
          end else begin
            // Nibbles 7..1 are final here; nibble 0 never affects the mask
            blank_mask <= blank_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Bench for bcd_digit_collector: a behavioural bcd_sequential stand-in plus directed and
// random conversions checked against decimal arithmetic.
module tb_bcd_digit_collector;

  logic        SYS_clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [25:0] in_bin = '0;
  logic [3:0]  conv_dec;
  logic        in_ready, conv_bin_en, conv_next_quotient, busy, out_valid;
  logic [25:0] conv_bin;
  logic [31:0] bcd_out;
  logic [7:0]  blank_mask;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0, nq_cnt = 0, overlap = 0;

  logic [25:0] m_val;
  int          m_d, m_busy;

  bcd_digit_collector dut (
    .SYS_clk(SYS_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .conv_bin(conv_bin), .conv_bin_en(conv_bin_en),
    .conv_next_quotient(conv_next_quotient), .conv_dec(conv_dec), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .blank_mask(blank_mask)
  );

  always #5 SYS_clk = ~SYS_clk;

  function automatic logic [3:0] dig(input logic [25:0] v, input int d);
    int x;
    x = int'(v);
    repeat (d) x = x / 10;
    return 4'(x % 10);
  endfunction

  function automatic logic [31:0] ref_bcd(input logic [25:0] v);
    logic [31:0] r;
    for (int d = 0; d < 8; d++) r[d*4 +: 4] = dig(v, d);
    return r;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [25:0] v);
    int n, x;
    logic [7:0] m;
    n = 1;
    x = int'(v);
    while (x >= 10) begin x = x / 10; n++; end
    m = 8'hFF;
    m = m << n;
    return m;
  endfunction

  // Converter stand-in: dec_out is garbage (F) while it works, valid after 3 op cycles
  // following bin_en and 4 following each next_quotient.
  always @(posedge SYS_clk) begin
    if (reset) begin
      m_busy   <= 0;
      conv_dec <= 4'hF;
    end else begin
      if (conv_bin_en) en_cnt <= en_cnt + 1;
      if (conv_next_quotient) nq_cnt <= nq_cnt + 1;
      if (conv_bin_en && conv_next_quotient) overlap <= overlap + 1;
      if (conv_bin_en) begin
        m_val <= conv_bin; m_d <= 7; m_busy <= 3; conv_dec <= 4'hF;
      end else if (conv_next_quotient) begin
        m_d <= m_d - 1; m_busy <= 4; conv_dec <= 4'hF;
      end else if (m_busy == 1) begin
        m_busy <= 0; conv_dec <= dig(m_val, m_d);
      end else if (m_busy > 1) begin
        m_busy <= m_busy - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic do_conv(input logic [25:0] v, input int hold, input bit toggle);
    int n, e0, q0;
    bit held_bad, hold_bad;
    n = 0;
    while (!in_ready && n < 100) begin step; n++; end
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    in_bin = v;
    in_valid = 1'b1;
    e0 = en_cnt;
    q0 = nq_cnt;
    step;
    in_valid = 1'b0;
    chk("conv_bin_latch", 32'(conv_bin), 32'(v));
    chk("busy_after_acc", 32'(busy), 32'd1);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    n = 1;
    held_bad = 1'b0;
    while (!out_valid && n < 200) begin
      if (toggle) in_bin = 26'($urandom);
      step;
      n++;
      if (conv_bin !== v) held_bad = 1'b1;
    end
    chk("latency", 32'(n), 32'd41);
    chk("bcd_out", bcd_out, ref_bcd(v));
    chk("blank_mask", 32'(blank_mask), 32'(ref_mask(v)));
    chk("busy_done", 32'(busy), 32'd0);
    chk("en_pulses", 32'(en_cnt - e0), 32'd1);
    chk("nq_pulses", 32'(nq_cnt - q0), 32'd7);
    chk("conv_bin_held", 32'(held_bad), 32'd0);
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin in_valid = 1'b1; in_bin = 26'd5; end
      step;
      if (!out_valid || bcd_out !== ref_bcd(v) || in_ready || conv_bin !== v || busy)
        hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    if (hold > 0) chk("hold_stable", 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("out_valid_taken", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    bit bad;
    logic [25:0] v;
    reset = 1'b1;
    step; step;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bin_en", 32'(conv_bin_en), 32'd0);
    chk("rst_nq", 32'(conv_next_quotient), 32'd0);
    chk("rst_bcd", bcd_out, 32'd0);
    chk("rst_mask", 32'(blank_mask), 32'd0);
    chk("rst_conv_bin", 32'(conv_bin), 32'd0);
    reset = 1'b0;
    step;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    do_conv(26'd12_345_678, 0, 1'b0);
    chk("lit_1234_5678", bcd_out, 32'h1234_5678);
    do_conv(26'd0, 0, 1'b0);
    chk("lit_mask_fe", 32'(blank_mask), 32'h0000_00FE);
    do_conv(26'd1000, 0, 1'b0);
    chk("lit_1000", bcd_out, 32'h0000_1000);
    do_conv(26'd67_108_863, 0, 1'b0);
    chk("lit_max", bcd_out, 32'h6710_8863);
    do_conv(26'd7_654_321, 20, 1'b0);
    do_conv(26'd40_000_000, 0, 1'b1);
    chk("lit_4000_0000", bcd_out, 32'h4000_0000);

    for (int i = 0; i < 8; i++) begin
      if (i[0]) v = 26'($urandom_range(0, 67_108_863));
      else v = 26'($urandom_range(0, 999));
      do_conv(v, int'($urandom_range(0, 3)), 1'b0);
    end

    // Abort mid-conversion with a reset in cycle 20
    in_bin = 26'd9_876_543;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (19) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_conv_bin", 32'(conv_bin), 32'd0);
    chk("abort_bcd", bcd_out, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    for (n = 0; n < 60; n++) begin
      step;
      if (out_valid || busy) bad = 1'b1;
    end
    chk("abort_no_result", 32'(bad), 32'd0);
    do_conv(26'd55_500_123, 0, 1'b0);

    chk("pulse_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
